// File: rtl/video_soft_switches_if.sv
// CPU bus view seen by the Apple II+ video soft-switch block.
// The CPU side drives the bus; the switch block only observes it.
interface video_soft_switches_if;
    logic        phase0;
    logic [15:0] addr;
    logic        rw;

    modport master (
        output phase0,
        output addr,
        output rw
    );

    modport slave (
        input phase0,
        input addr,
        input rw
    );
endinterface

// File: rtl/video_soft_switches.sv
// Apple II+ video soft switches $C050-$C057; mode changes held until a line edge.
// Define ANNUNCIATOR_EN to add the AN3..AN0 annunciators at $C058-$C05F.
module video_soft_switches #(
    parameter logic [6:0] H_LINE_START = 7'h00
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    video_soft_switches_if.slave  bus,
    input  logic [6:0]            H,
    output logic                  text_mode,
    output logic                  mix_mode,
    output logic                  page2,
    output logic                  hires_mode,
    output logic                  switch_strobe
`ifdef ANNUNCIATOR_EN
    ,
    output logic [3:0]            an
`endif
);

    logic       phase0_q, phase0_d;
    logic [6:0] h_q, h_d;
    logic       p_text_q, p_text_d;
    logic       p_mix_q, p_mix_d;
    logic       p_page2_q, p_page2_d;
    logic       p_hires_q, p_hires_d;
    logic       text_q, text_d;
    logic       mix_q, mix_d;
    logic       page2_q, page2_d;
    logic       hires_q, hires_d;
    logic       strobe_q, strobe_d;
`ifdef ANNUNCIATOR_EN
    logic [3:0] an_q, an_d;
`endif

    logic hit;
    logic fall;
    logic commit;
    logic boundary;
    logic rw_unused;

    // Reads and writes toggle switches alike, so rw carries no meaning here.
    assign rw_unused = bus.rw;

`ifdef ANNUNCIATOR_EN
    assign hit = (bus.addr[15:4] == 12'hC05);
`else
    assign hit = (bus.addr[15:3] == 13'h180A);
`endif

    assign fall     = phase0_q & ~bus.phase0;
    assign commit   = fall & hit;
    assign boundary = (H == H_LINE_START) && (h_q != H_LINE_START);

    always_comb begin
        phase0_d  = bus.phase0;
        h_d       = H;
        p_text_d  = p_text_q;
        p_mix_d   = p_mix_q;
        p_page2_d = p_page2_q;
        p_hires_d = p_hires_q;
        text_d    = text_q;
        mix_d     = mix_q;
        page2_d   = page2_q;
        hires_d   = hires_q;
        strobe_d  = commit;
`ifdef ANNUNCIATOR_EN
        an_d      = an_q;
`endif

        // Applied outputs take the pre-commit pending values.
        if (boundary) begin
            text_d  = p_text_q;
            mix_d   = p_mix_q;
            page2_d = p_page2_q;
            hires_d = p_hires_q;
        end

        if (commit && !bus.addr[3]) begin
            unique case (bus.addr[2:1])
                2'd0: p_text_d  = bus.addr[0];
                2'd1: p_mix_d   = bus.addr[0];
                2'd2: p_page2_d = bus.addr[0];
                2'd3: p_hires_d = bus.addr[0];
                default: ;
            endcase
        end

`ifdef ANNUNCIATOR_EN
        if (commit && bus.addr[3]) begin
            an_d[bus.addr[2:1]] = bus.addr[0];
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            phase0_q  <= 1'b0;
            h_q       <= H_LINE_START;
            p_text_q  <= 1'b1;
            p_mix_q   <= 1'b0;
            p_page2_q <= 1'b0;
            p_hires_q <= 1'b0;
            text_q    <= 1'b1;
            mix_q     <= 1'b0;
            page2_q   <= 1'b0;
            hires_q   <= 1'b0;
            strobe_q  <= 1'b0;
`ifdef ANNUNCIATOR_EN
            an_q      <= 4'b0000;
`endif
        end else begin
            phase0_q  <= phase0_d;
            h_q       <= h_d;
            p_text_q  <= p_text_d;
            p_mix_q   <= p_mix_d;
            p_page2_q <= p_page2_d;
            p_hires_q <= p_hires_d;
            text_q    <= text_d;
            mix_q     <= mix_d;
            page2_q   <= page2_d;
            hires_q   <= hires_d;
            strobe_q  <= strobe_d;
`ifdef ANNUNCIATOR_EN
            an_q      <= an_d;
`endif
        end
    end

    assign text_mode     = text_q;
    assign mix_mode      = mix_q;
    assign page2         = page2_q;
    assign hires_mode    = hires_q;
    assign switch_strobe = strobe_q;
`ifdef ANNUNCIATOR_EN
    assign an            = an_q;
`endif

endmodule
